ram_dp_clr: RTL and testbench
=============================

# ram_dp_clr

Parametrised simple dual-port synchronous RAM: one write port, one independent registered read port, and a built-in clear engine that sweeps every location to a constant. It succeeds the fixed 8-bit x 64-entry single-port RAM and adds three things that block lacks: configurable width and depth, a selectable read-during-write mode, and a guaranteed-known memory state after reset. It sits wherever the design needs scratch storage with concurrent fill and drain, for example a line buffer or a small lookup table.

## Interface

Parameters:
- DATA_W, 8, data width in bits (≥1)
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W entries
- RDW_MODE, 0, same-address read-during-write result: 0 = old data (read-first), 1 = new data (write-first)
- CLR_VAL, 0, DATA_W-bit value written to every location by the clear engine

Ports:
- clk, in, 1, single clock; all logic on the rising edge
- rst, in, 1, reset, synchronous, active-high; also starts a clear sweep
- clr, in, 1, clear request; sampled only in IDLE
- busy, out, 1, high while the clear sweep runs
- we, in, 1, write enable, port A
- waddr, in, ADDR_W, write address
- data, in, DATA_W, write data
- re, in, 1, read enable, port B
- raddr, in, ADDR_W, read address
- q, out, DATA_W, registered read data
- q_valid, out, 1, one-cycle pulse marking new data on q

## Operation

- The state machine has two states: CLEAR and IDLE. A clear pointer, clr_ptr, is ADDR_W bits wide.
- Reset (rst=1 at an edge): state=CLEAR, clr_ptr=0, busy=1, q=0, q_valid=0. Memory contents are not reset directly; the sweep initialises them.
- CLEAR, rst=0: each cycle writes CLR_VAL to mem[clr_ptr], then increments clr_ptr.
  - At clr_ptr = DEPTH-1 the block does that write and then moves to IDLE. clr_ptr does not wrap further.
- IDLE, clr=1: clr_ptr=0 and the state becomes CLEAR. clr is ignored in CLEAR; there is no queuing and no restart.
- busy = (state == CLEAR). It is a registered output.
- In CLEAR, we and re are ignored: writes are dropped, q holds its value, q_valid=0.
- In IDLE, with we=1: mem[waddr] <= data at the edge.
- In IDLE, with re=1: q <= mem[raddr] and q_valid <= 1. With re=0, q holds its value and q_valid <= 0.
- Same-cycle we=1 and re=1 with waddr == raddr:
  - RDW_MODE=0: q gets the pre-write contents.
  - RDW_MODE=1: q gets data.
- Different addresses on the two ports are fully independent.
- rst asserted mid-sweep restarts the sweep from address 0. rst asserted in IDLE starts a new sweep, which destroys the contents.

## Timing

- Read latency is 1: re/raddr sampled at edge n gives q and q_valid valid after edge n, readable at edge n+1.
- Write latency is 1: data written at edge n is visible to a read issued at edge n+1. For a same-edge read, RDW_MODE applies.
- Clear duration:
  - busy stays high for exactly DEPTH cycles after the first edge with rst=0 (64 cycles at defaults).
  - The first edge with busy=0 accepts we and re.
- The clr to busy path: clr=1 at edge n (in IDLE) gives busy=1 after edge n. The sweep lasts DEPTH cycles. we/re at edge n are still serviced, because state was IDLE at that edge.
- Back-to-back reads or writes are allowed every cycle. Throughput is 1 write plus 1 read per cycle.

## Test plan

- Reset then release: busy high for exactly 64 cycles, q=0, q_valid=0 throughout. After that, reading addresses 0, 31 and 63 returns 8'h00, each with a single q_valid pulse. Repeat with CLR_VAL=8'hA5 and expect 8'hA5.
- Writes then reads: after the sweep, write 8'h01, 8'h02, 8'h03 to addresses 0, 1, 2 on consecutive cycles, then read 0, 1, 2 on consecutive cycles. Expect q = 01, 02, 03, one cycle after each re, with q_valid high for 3 cycles. Overwrite address 1 with 8'h04 and read it back as 04. Read unwritten address 3 and get CLR_VAL.
- Collision: write 8'h5A to address 7 (previously 8'h11) while reading address 7 in the same cycle. Expect q=11 with RDW_MODE=0 and q=5A with RDW_MODE=1. On the next-cycle read of address 7, both modes return 5A.
- Access during busy: assert clr in IDLE, then drive we=1 (address 9, data 8'hFF) and re=1 while busy. Expect q_valid=0 and q unchanged. After the sweep, address 9 reads CLR_VAL. A second clr pulse mid-sweep does not extend busy beyond 64 cycles.
- Reset mid-sweep: assert rst for 1 cycle at sweep cycle 20. busy then stays high 64 cycles from the release, and addresses 0 and 63 read CLR_VAL afterwards.
- Parametrisation: with DATA_W=16 and ADDR_W=3, busy lasts 8 cycles. Write 16'hBEEF to address 7 and read it back as BEEF. Address 7 is the last entry; nothing wraps to address 0.

Source files
------------

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM (1 write, 1 registered read) with a clear sweep after reset/clr.
// Read latency 1; no backpressure, but busy drops both ports for DEPTH cycles per sweep.
module ram_dp_clr #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 6,
  parameter int                RDW_MODE = 0,
  parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] data,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q,
  output logic              q_valid
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic                q_valid_q, q_valid_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdat;
  logic [DATA_W-1:0]   rd_dat;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    q_d       = q_q;
    q_valid_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdat  = data;

    // Write-first bypasses the array so q sees the incoming word on a collision.
    rd_dat = mem[raddr];
    if ((RDW_MODE != 0) && we && (waddr == raddr)) begin
      rd_dat = data;
    end

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdat  = CLR_VAL;
        if (&clr_ptr_q) begin
          state_d = ST_IDLE;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      default: begin
        mem_we = we;
        if (re) begin
          q_d       = rd_dat;
          q_valid_d = 1'b1;
        end
        if (clr) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  // The array itself carries no reset; the sweep that follows reset initialises it.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[mem_waddr] <= mem_wdat;
    end
  end

  assign busy    = (state_q == ST_CLEAR);
  assign q       = q_q;
  assign q_valid = q_valid_q;

endmodule

// File: tb/tb_ram_dp_clr.sv
// Bench for ram_dp_clr: two 8x64 instances (read-first/0x00, write-first/0xA5) and one 16x8.
// Directed scenarios followed by random traffic, all checked against an array-level model.
module tb_ram_dp_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, we, re;
  logic [5:0]  waddr, raddr;
  logic [7:0]  data;
  logic        busy0, busy1, qv0, qv1;
  logic [7:0]  q0, q1;

  logic        s_we, s_re;
  logic [2:0]  s_waddr, s_raddr;
  logic [15:0] s_data, s_q;
  logic        s_busy, s_qv;

  ram_dp_clr #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(0), .CLR_VAL(8'h00)) u_rf (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy0), .we(we), .waddr(waddr), .data(data),
    .re(re), .raddr(raddr), .q(q0), .q_valid(qv0));

  ram_dp_clr #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(1), .CLR_VAL(8'hA5)) u_wf (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy1), .we(we), .waddr(waddr), .data(data),
    .re(re), .raddr(raddr), .q(q1), .q_valid(qv1));

  ram_dp_clr #(.DATA_W(16), .ADDR_W(3), .RDW_MODE(0), .CLR_VAL(16'h0000)) u_sm (
    .clk(clk), .rst(rst), .clr(clr), .busy(s_busy), .we(s_we), .waddr(s_waddr), .data(s_data),
    .re(s_re), .raddr(s_raddr), .q(s_q), .q_valid(s_qv));

  // Reference model: array contents, remaining sweep cycles, expected q per instance.
  logic [7:0]  m0 [64];
  logic [7:0]  m1 [64];
  logic [15:0] ms [8];
  int          bc8, bcs;
  logic [7:0]  eq0, eq1;
  logic [15:0] eqs;
  logic        ev8, evs;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    rst = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0;
    waddr = '0; raddr = '0; data = '0;
    s_we = 1'b0; s_re = 1'b0; s_waddr = '0; s_raddr = '0; s_data = '0;
  endtask

  task automatic step();
    if (rst) begin
      bc8 = 64; eq0 = 8'h00; eq1 = 8'h00; ev8 = 1'b0;
      for (int i = 0; i < 64; i++) begin m0[i] = 8'h00; m1[i] = 8'hA5; end
    end else if (bc8 > 0) begin
      bc8--; ev8 = 1'b0;
    end else begin
      if (re) begin
        eq0 = m0[raddr];
        eq1 = (we && waddr == raddr) ? data : m1[raddr];
      end
      ev8 = re;
      if (we) begin m0[waddr] = data; m1[waddr] = data; end
      if (clr) begin
        bc8 = 64;
        for (int i = 0; i < 64; i++) begin m0[i] = 8'h00; m1[i] = 8'hA5; end
      end
    end

    if (rst) begin
      bcs = 8; eqs = 16'h0000; evs = 1'b0;
      for (int i = 0; i < 8; i++) ms[i] = 16'h0000;
    end else if (bcs > 0) begin
      bcs--; evs = 1'b0;
    end else begin
      if (s_re) eqs = ms[s_raddr];
      evs = s_re;
      if (s_we) ms[s_waddr] = s_data;
      if (clr) begin
        bcs = 8;
        for (int i = 0; i < 8; i++) ms[i] = 16'h0000;
      end
    end

    @(posedge clk);
    #1;
    chk("busy_rf", 32'(busy0), 32'(bc8 > 0));
    chk("busy_wf", 32'(busy1), 32'(bc8 > 0));
    chk("busy_sm", 32'(s_busy), 32'(bcs > 0));
    chk("qv_rf", 32'(qv0), 32'(ev8));
    chk("qv_wf", 32'(qv1), 32'(ev8));
    chk("qv_sm", 32'(s_qv), 32'(evs));
    chk("q_rf", 32'(q0), 32'(eq0));
    chk("q_wf", 32'(q1), 32'(eq1));
    chk("q_sm", 32'(s_q), 32'(eqs));
  endtask

  // Steps while the 8-bit instances are busy; returns cycles seen with busy high.
  task automatic busy_len(output int n8, output int ns);
    n8 = 0; ns = 0;
    while (busy0 && n8 < 200) begin
      n8++;
      if (s_busy) ns++;
      step();
    end
  endtask

  task automatic rd8(input logic [5:0] a, input logic [7:0] exp0, input logic [7:0] exp1,
                     input string tag);
    re = 1'b1; raddr = a; step();
    chk({tag, "_q_rf"}, 32'(q0), 32'(exp0));
    chk({tag, "_q_wf"}, 32'(q1), 32'(exp1));
    chk({tag, "_qv"}, 32'(qv0), 32'd1);
    re = 1'b0;
  endtask

  task automatic wr8(input logic [5:0] a, input logic [7:0] d);
    we = 1'b1; waddr = a; data = d; step();
    we = 1'b0;
  endtask

  int n8, ns;

  initial begin
    set_idle();
    bc8 = 0; bcs = 0; eq0 = 0; eq1 = 0; eqs = 0; ev8 = 0; evs = 0;
    for (int i = 0; i < 64; i++) begin m0[i] = 0; m1[i] = 0; end
    for (int i = 0; i < 8; i++) ms[i] = 0;

    // Reset state and initial sweep length
    rst = 1'b1; step(); step();
    chk("rst_q", 32'(q0), 32'h0);
    chk("rst_qv", 32'(qv0), 32'h0);
    rst = 1'b0;
    busy_len(n8, ns);
    chk("sweep_len", 32'(n8), 32'd64);
    chk("sweep_len_sm", 32'(ns), 32'd8);

    rd8(6'd0,  8'h00, 8'hA5, "clr0");
    step();
    chk("qv_single", 32'(qv0), 32'd0);
    rd8(6'd31, 8'h00, 8'hA5, "clr31");
    rd8(6'd63, 8'h00, 8'hA5, "clr63");
    step();

    // Writes then back-to-back reads
    wr8(6'd0, 8'h01); wr8(6'd1, 8'h02); wr8(6'd2, 8'h03);
    rd8(6'd0, 8'h01, 8'h01, "rd0");
    rd8(6'd1, 8'h02, 8'h02, "rd1");
    rd8(6'd2, 8'h03, 8'h03, "rd2");
    wr8(6'd1, 8'h04);
    rd8(6'd1, 8'h04, 8'h04, "ovw1");
    rd8(6'd3, 8'h00, 8'hA5, "unwr3");

    // Read-during-write collision
    wr8(6'd7, 8'h11);
    we = 1'b1; waddr = 6'd7; data = 8'h5A;
    rd8(6'd7, 8'h11, 8'h5A, "coll");
    we = 1'b0;
    rd8(6'd7, 8'h5A, 8'h5A, "after_coll");

    // Accesses while busy are dropped; a second clr does not extend the sweep
    clr = 1'b1; step(); clr = 1'b0;
    we = 1'b1; waddr = 6'd9; data = 8'hFF; re = 1'b1; raddr = 6'd9;
    n8 = 0;
    while (busy0 && n8 < 200) begin
      n8++;
      clr = (n8 == 30);
      step();
      if (busy0) chk("busy_qv", 32'(qv0), 32'd0);
    end
    chk("clr_sweep_len", 32'(n8), 32'd64);
    set_idle();
    rd8(6'd9, 8'h00, 8'hA5, "busy_wr9");

    // Reset mid-sweep restarts from address 0
    clr = 1'b1; step(); clr = 1'b0;
    repeat (20) step();
    rst = 1'b1; step(); rst = 1'b0;
    busy_len(n8, ns);
    chk("rst_mid_len", 32'(n8), 32'd64);
    rd8(6'd0,  8'h00, 8'hA5, "mid0");
    rd8(6'd63, 8'h00, 8'hA5, "mid63");

    // Narrow/wide instance: last entry does not alias address 0
    s_we = 1'b1; s_waddr = 3'd7; s_data = 16'hBEEF; step(); s_we = 1'b0;
    s_re = 1'b1; s_raddr = 3'd7; step();
    chk("sm_beef", 32'(s_q), 32'h0000BEEF);
    s_raddr = 3'd0; step();
    chk("sm_nowrap", 32'(s_q), 32'h00000000);
    s_re = 1'b0;

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      rst     = ($urandom_range(0, 499) == 0);
      clr     = ($urandom_range(0, 99) == 0);
      we      = $urandom_range(0, 1) == 1;
      re      = $urandom_range(0, 1) == 1;
      waddr   = 6'($urandom);
      raddr   = ($urandom_range(0, 3) == 0) ? waddr : 6'($urandom);
      data    = 8'($urandom);
      s_we    = $urandom_range(0, 1) == 1;
      s_re    = $urandom_range(0, 1) == 1;
      s_waddr = 3'($urandom);
      s_raddr = 3'($urandom);
      s_data  = 16'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
